// File: rtl/layer_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : layer_accumulator
//  Purpose  : Spiking-layer accumulator that sits downstream of rom_layer.
//             Latches one input spike vector, scans the inputs one per cycle,
//             and addresses rom_layer one-hot for each active input. Each
//             returned signed weight row is added into NEURON_OUT saturating
//             accumulators. The final sums are thresholded into an output
//             spike vector and handed on over a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   clock, rising edge
//    rst_n      in   asynchronous active-low reset
//    in_valid   in   in_spikes is valid
//    in_ready   out  block can accept a new vector (IDLE only)
//    in_spikes  in   [NEURON_IN]            input activations
//    rom_addr   out  [NEURON_IN]            one-hot row address to rom_layer
//    rom_data   in   [NEURON_OUT*W_SIZE]    weight row, neuron j at j*W_SIZE
//    out_valid  out  out_spikes/out_acc valid (DONE only)
//    out_ready  in   downstream accepts result
//    out_spikes out  [NEURON_OUT]           bit j = out_acc[j] > THRESHOLD
//    out_acc    out  [NEURON_OUT*ACC_SIZE]  final sums, neuron j at j*ACC_SIZE
// ============================================================================
module layer_accumulator #(
  parameter int W_SIZE     = 8,
  parameter int NEURON_IN  = 4,
  parameter int NEURON_OUT = 2,
  parameter int ACC_SIZE   = 16,
  parameter logic signed [ACC_SIZE-1:0] THRESHOLD = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NEURON_IN-1:0]           in_spikes,
  output logic [NEURON_IN-1:0]           rom_addr,
  input  logic [NEURON_OUT*W_SIZE-1:0]   rom_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [NEURON_OUT-1:0]          out_spikes,
  output logic [NEURON_OUT*ACC_SIZE-1:0] out_acc
);

  localparam int IDX_W = (NEURON_IN > 1) ? $clog2(NEURON_IN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NEURON_IN - 1);
  localparam logic signed [ACC_SIZE-1:0] ACC_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
  localparam logic signed [ACC_SIZE-1:0] ACC_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, next_state;

  logic [IDX_W-1:0]               idx;
  logic [NEURON_IN-1:0]           spikes_latch;
  logic [NEURON_OUT*ACC_SIZE-1:0] acc;
  logic [NEURON_OUT*ACC_SIZE-1:0] acc_next;
  logic [NEURON_OUT-1:0]          fire_next;
  logic                           active;

  // Only a set latch bit in SCAN contributes; otherwise rom_data is ignored.
  assign active = (state == SCAN) && spikes_latch[idx];

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // --------------------------------------------------------------------------
  // Next-state and handshake / ROM address outputs
  // --------------------------------------------------------------------------
  always_comb begin
    next_state = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    rom_addr   = '0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) next_state = SCAN;
      end
      SCAN: begin
        if (spikes_latch[idx]) rom_addr[idx] = 1'b1;
        if (idx == LAST_IDX) next_state = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Per-neuron saturating adder. The sum is formed one bit wider than the
  // accumulator; disagreement of the top two bits means overflow, and the
  // wider sign bit gives the true direction to clamp towards.
  // --------------------------------------------------------------------------
  for (genvar j = 0; j < NEURON_OUT; j++) begin : g_neuron
    logic [W_SIZE-1:0]          w;
    logic [ACC_SIZE-1:0]        cur;
    logic [ACC_SIZE:0]          wide_sum;
    logic signed [ACC_SIZE-1:0] sum;

    assign w        = rom_data[j*W_SIZE +: W_SIZE];
    assign cur      = acc[j*ACC_SIZE +: ACC_SIZE];
    assign wide_sum = {cur[ACC_SIZE-1], cur}
                    + {{(ACC_SIZE+1-W_SIZE){w[W_SIZE-1]}}, w};

    always_comb begin
      sum = cur;
      if (active) begin
        if (wide_sum[ACC_SIZE] != wide_sum[ACC_SIZE-1])
          sum = wide_sum[ACC_SIZE] ? ACC_MIN : ACC_MAX;
        else
          sum = wide_sum[ACC_SIZE-1:0];
      end
    end

    assign acc_next[j*ACC_SIZE +: ACC_SIZE] = sum;
    assign fire_next[j]                     = (sum > THRESHOLD);
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx          <= '0;
      spikes_latch <= '0;
      acc          <= '0;
      out_spikes   <= '0;
      out_acc      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            spikes_latch <= in_spikes;
            acc          <= '0;
            idx          <= '0;
          end
        end
        SCAN: begin
          acc <= acc_next;
          idx <= idx + IDX_W'(1);
          // Results are captured straight from the final adder output so
          // out_valid and the data appear together on entry to DONE.
          if (idx == LAST_IDX) begin
            out_acc    <= acc_next;
            out_spikes <= fire_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_layer_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_layer_accumulator
//  Purpose  : Self-checking bench for layer_accumulator. Two instances share
//             the handshake stimulus: dut_a (ACC_SIZE=16) with ROM table rom_a
//             and dut_b (ACC_SIZE=8) with ROM table rom_b for saturation.
//  Revision : 1.0  initial release
// ============================================================================
module tb_layer_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [3:0]  in_spikes;
  logic        out_ready;

  logic        in_ready_a, out_valid_a;
  logic [3:0]  rom_addr_a;
  logic [15:0] rom_data_a;
  logic [1:0]  out_spikes_a;
  logic [31:0] out_acc_a;

  logic        in_ready_b, out_valid_b;
  logic [3:0]  rom_addr_b;
  logic [15:0] rom_data_b;
  logic [1:0]  out_spikes_b;
  logic [15:0] out_acc_b;

  logic signed [7:0] rom_a [4][2];
  logic signed [7:0] rom_b [4][2];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  layer_accumulator #(.W_SIZE(8), .NEURON_IN(4), .NEURON_OUT(2), .ACC_SIZE(16)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_spikes(in_spikes), .rom_addr(rom_addr_a), .rom_data(rom_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_spikes(out_spikes_a),
    .out_acc(out_acc_a)
  );

  layer_accumulator #(.W_SIZE(8), .NEURON_IN(4), .NEURON_OUT(2), .ACC_SIZE(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_spikes(in_spikes), .rom_addr(rom_addr_b), .rom_data(rom_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_spikes(out_spikes_b),
    .out_acc(out_acc_b)
  );

  // Combinational ROMs: a one-hot address selects a row, anything else reads 0.
  always_comb begin
    rom_data_a = '0;
    rom_data_b = '0;
    for (int i = 0; i < 4; i++) begin
      if (rom_addr_a == 4'(1 << i))
        for (int j = 0; j < 2; j++) rom_data_a[j*8 +: 8] = rom_a[i][j];
      if (rom_addr_b == 4'(1 << i))
        for (int j = 0; j < 2; j++) rom_data_b[j*8 +: 8] = rom_b[i][j];
    end
  end

  // Reference: sum the weight rows of active inputs in order, clamping after
  // every addition to the signed range of the accumulator width.
  function automatic int model_acc(input logic [3:0] s, input int j,
                                   input bit use_b, input int asz);
    int lo, hi, a;
    lo = -(1 <<< (asz - 1));
    hi = (1 <<< (asz - 1)) - 1;
    a  = 0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        a = a + (use_b ? int'(rom_b[i][j]) : int'(rom_a[i][j]));
        if (a > hi) a = hi;
        if (a < lo) a = lo;
      end
    end
    return a;
  endfunction

  task automatic set_spec_roms();
    rom_a[0][0] = 8'sd5;  rom_a[0][1] = -8'sd3;
    rom_a[1][0] = -8'sd1; rom_a[1][1] = 8'sd4;
    rom_a[2][0] = 8'sd2;  rom_a[2][1] = 8'sd2;
    rom_a[3][0] = -8'sd7; rom_a[3][1] = 8'sd1;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) rom_b[i][j] = 8'sd127;
  endtask

  // Drive one vector through both DUTs, checking the ROM address sequence,
  // fixed latency, results, and hold behaviour for 'stall' cycles of
  // backpressure (with a stray in_valid that must be ignored).
  task automatic run_vector(input logic [3:0] s, input int stall);
    int t;
    int ea, eb, ga, gb;
    logic [3:0]  exp_addr;
    logic [31:0] hold_acc_a;
    logic [15:0] hold_acc_b;
    logic [1:0]  hold_sp_a, hold_sp_b;
    t = 0;
    while (!(in_ready_a && in_ready_b) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    total++;
    if (!(in_ready_a && in_ready_b)) begin
      bad++;
      $display("FAIL ready_timeout: in_ready a=%0b b=%0b, required 1", in_ready_a, in_ready_b);
      return;
    end
    in_valid  = 1'b1;
    in_spikes = s;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_spikes = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      exp_addr = s[i] ? 4'(1 << i) : 4'd0;
      total++;
      if (rom_addr_a !== exp_addr || rom_addr_b !== exp_addr || out_valid_a !== 1'b0
          || in_ready_a !== 1'b0) begin
        bad++;
        $display("FAIL scan[%0d] spikes=%b: addr a=%b b=%b valid=%b rdy=%b, required addr=%b valid=0 rdy=0",
                 i, s, rom_addr_a, rom_addr_b, out_valid_a, in_ready_a, exp_addr);
      end
      @(posedge clk); #1;
    end
    total++;
    if (out_valid_a !== 1'b1 || out_valid_b !== 1'b1 || rom_addr_a !== 4'd0) begin
      bad++;
      $display("FAIL latency spikes=%b: out_valid a=%b b=%b addr=%b, required 1 1 0000",
               s, out_valid_a, out_valid_b, rom_addr_a);
    end
    for (int j = 0; j < 2; j++) begin
      ea = model_acc(s, j, 1'b0, 16);
      eb = model_acc(s, j, 1'b1, 8);
      ga = int'($signed(out_acc_a[j*16 +: 16]));
      gb = int'($signed(out_acc_b[j*8 +: 8]));
      total++;
      if (ga != ea || gb != eb || out_spikes_a[j] !== (ea > 0) || out_spikes_b[j] !== (eb > 0)) begin
        bad++;
        $display("FAIL result n%0d spikes=%b: acc a=%0d b=%0d fire a=%b b=%b, required acc %0d %0d fire %0b %0b",
                 j, s, ga, gb, out_spikes_a[j], out_spikes_b[j], ea, eb, ea > 0, eb > 0);
      end
    end
    hold_acc_a = out_acc_a;  hold_acc_b = out_acc_b;
    hold_sp_a  = out_spikes_a; hold_sp_b = out_spikes_b;
    for (int c = 0; c < stall; c++) begin
      in_valid  = 1'b1;
      in_spikes = 4'($urandom);
      @(posedge clk); #1;
      total++;
      if (out_valid_a !== 1'b1 || in_ready_a !== 1'b0 || out_acc_a !== hold_acc_a
          || out_acc_b !== hold_acc_b || out_spikes_a !== hold_sp_a || out_spikes_b !== hold_sp_b
          || out_valid_b !== 1'b1) begin
        bad++;
        $display("FAIL hold[%0d]: valid=%b rdy=%b acc=%h/%h sp=%b/%b, required 1 0 %h/%h %b/%b",
                 c, out_valid_a, in_ready_a, out_acc_a, out_acc_b, out_spikes_a, out_spikes_b,
                 hold_acc_a, hold_acc_b, hold_sp_a, hold_sp_b);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1 || out_valid_b !== 1'b0 || in_ready_b !== 1'b1
        || out_acc_a !== hold_acc_a || out_spikes_a !== hold_sp_a) begin
      bad++;
      $display("FAIL release: valid=%b/%b rdy=%b/%b acc=%h sp=%b, required 0/0 1/1 %h %b",
               out_valid_a, out_valid_b, in_ready_a, in_ready_b, out_acc_a, out_spikes_a,
               hold_acc_a, hold_sp_a);
    end
  endtask

  task automatic check_reset_values(input string tag);
    total++;
    if (in_ready_a !== 1'b1 || out_valid_a !== 1'b0 || rom_addr_a !== 4'd0
        || out_spikes_a !== 2'd0 || out_acc_a !== 32'd0
        || in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || rom_addr_b !== 4'd0
        || out_spikes_b !== 2'd0 || out_acc_b !== 16'd0) begin
      bad++;
      $display("FAIL %s: rdy=%b/%b valid=%b/%b addr=%b/%b sp=%b/%b acc=%h/%h, required 1 0 0 0 0",
               tag, in_ready_a, in_ready_b, out_valid_a, out_valid_b, rom_addr_a, rom_addr_b,
               out_spikes_a, out_spikes_b, out_acc_a, out_acc_b);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_spikes = 4'd0; out_ready = 1'b1;
    #1;
    check_reset_values("reset_async");
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_values("reset_after_release");
  endtask

  task automatic test_spec_vectors();
    set_spec_roms();
    run_vector(4'b1111, 0);
    run_vector(4'b0101, 0);
    run_vector(4'b0000, 0);
  endtask

  task automatic test_saturation();
    run_vector(4'b1111, 0);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 2; j++) rom_b[i][j] = -8'sd128;
    run_vector(4'b1111, 0);
    // Pin high, then pull back inside range with a negative term.
    rom_b[0][0] = 8'sd127; rom_b[1][0] = 8'sd127; rom_b[2][0] = -8'sd100; rom_b[3][0] = 8'sd3;
    rom_b[0][1] = -8'sd128; rom_b[1][1] = -8'sd128; rom_b[2][1] = 8'sd100; rom_b[3][1] = -8'sd1;
    run_vector(4'b1111, 0);
  endtask

  task automatic test_backpressure();
    set_spec_roms();
    run_vector(4'b1011, 5);
  endtask

  task automatic test_reset_mid_scan();
    set_spec_roms();
    in_valid = 1'b1; in_spikes = 4'b1111; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (rom_addr_a !== 4'b0100) begin
      bad++;
      $display("FAIL pre_abort_addr: rom_addr=%b, required 0100", rom_addr_a);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid_scan");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      total++;
      if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
        bad++;
        $display("FAIL aborted_valid[%0d]: out_valid=%b/%b, required 0", c, out_valid_a, out_valid_b);
      end
    end
    run_vector(4'b0110, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 2; j++) begin
          rom_a[i][j] = 8'($urandom);
          rom_b[i][j] = 8'($urandom);
        end
      run_vector(4'($urandom), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_back_to_back();
    set_spec_roms();
    for (int k = 0; k < 4; k++) run_vector(4'($urandom), 0);
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_saturation();
    test_backpressure();
    test_reset_mid_scan();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
